// File: rtl/perf_counter_pkg.sv
// rtl/perf_counter_pkg.sv - shared register map, CFG layout and constants for the perf counter bank
package perf_counter_pkg;

    localparam logic [7:0] ADDR_GLOBAL_CTRL = 8'h00;
    localparam logic [7:0] ADDR_OVF_STATUS  = 8'h04;
    localparam logic [7:0] ADDR_IRQ_MASK    = 8'h08;
    localparam logic [7:0] ADDR_INFO        = 8'h0C;
    localparam logic [7:0] ADDR_CNT_BASE    = 8'h40;

    // Word offsets within a counter's 16-byte window; word 3 is a hole.
    localparam logic [1:0] OFF_CFG = 2'd0;
    localparam logic [1:0] OFF_LO  = 2'd1;
    localparam logic [1:0] OFF_HI  = 2'd2;

    localparam logic [7:0] CYCLE_SEL    = 8'hFF;
    localparam logic [7:0] INFO_VERSION = 8'h01;

    typedef struct packed {
        logic       en;
        logic [7:0] sel;
    } cfg_t;

endpackage

// File: rtl/perf_counter_slice.sv
// rtl/perf_counter_slice.sv - one counter with its CFG register, event mux and wrap detect
module perf_counter_slice
    import perf_counter_pkg::*;
#(
    parameter int NUM_EVENTS = 16,
    parameter int CNT_WIDTH  = 48
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_EVENTS-1:0] events_i,
    input  logic                  count_en_i,
    input  logic                  clear_i,
    input  logic                  cfg_we_i,
    input  logic                  lo_we_i,
    input  logic                  hi_we_i,
    input  logic [31:0]           wdata_i,
    output cfg_t                  cfg_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  wrap_o
);

    localparam logic [8:0] NEV = 9'(NUM_EVENTS);

    cfg_t                 cfg_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] lo_preset;
    logic [CNT_WIDTH-1:0] hi_preset;
    logic [255:0]         ev_ext;
    logic                 hit;
    logic                 inc;

    assign ev_ext = 256'(events_i);

    generate
        if (CNT_WIDTH > 32) begin : g_wide
            assign lo_preset = {cnt_q[CNT_WIDTH-1:32], wdata_i};
            assign hi_preset = {wdata_i[CNT_WIDTH-33:0], cnt_q[31:0]};
        end else begin : g_narrow
            assign lo_preset = wdata_i;
            assign hi_preset = cnt_q;
        end
    endgenerate

    always_comb begin
        hit = 1'b0;
        if ({1'b0, cfg_q.sel} < NEV) begin
            hit = ev_ext[cfg_q.sel];
        end else if (cfg_q.sel == CYCLE_SEL) begin
            hit = 1'b1;
        end
    end

    assign inc = count_en_i & cfg_q.en & hit;

    // clear_all beats a software preset, which beats the increment.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_o = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (lo_we_i) begin
            cnt_d = lo_preset;
        end else if (hi_we_i) begin
            cnt_d = hi_preset;
        end else if (inc) begin
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            wrap_o = &cnt_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (cfg_we_i) begin
                cfg_q <= cfg_t'(wdata_i[8:0]);
            end
        end
    end

    assign cfg_o   = cfg_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - configurable event counter bank; PERF_SNAPSHOT_EN adds a snapshot bank
module perf_counter_bank
    import perf_counter_pkg::*;
#(
    parameter int NUM_EVENTS   = 16,
    parameter int NUM_COUNTERS = 8,
    parameter int CNT_WIDTH    = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_EVENTS-1:0]   events,
    input  logic                    freeze,
    input  logic                    reg_req,
    input  logic                    reg_we,
    input  logic [7:0]              reg_addr,
    input  logic [31:0]             reg_wdata,
    output logic [31:0]             reg_rdata,
    output logic                    reg_ack,
    output logic                    reg_err,
    output logic [NUM_COUNTERS-1:0] ovf,
    output logic                    irq
);

    localparam logic [4:0] NC5 = 5'(NUM_COUNTERS);

    logic                    enable_q;
    logic [NUM_COUNTERS-1:0] irq_mask_q;
    logic [NUM_COUNTERS-1:0] ovf_q;
    logic [NUM_COUNTERS-1:0] ovf_d;
    logic [31:0]             shadow_q;
    logic [31:0]             rdata_q;
    logic                    ack_q;
    logic                    err_q;
    logic                    irq_q;

    logic                    wr_en;
    logic                    rd_en;
    logic                    is_ctrl;
    logic                    is_ovf;
    logic                    is_mask;
    logic                    is_info;
    logic                    is_cnt;
    logic                    mapped;
    logic [3:0]              cnt_idx;
    logic [1:0]              cnt_off;
    logic                    clear_all;
    logic                    count_en;
    logic                    snap_sel_rd;
    logic [NUM_COUNTERS-1:0] w1c;

    logic [NUM_COUNTERS-1:0] cfg_we;
    logic [NUM_COUNTERS-1:0] lo_we;
    logic [NUM_COUNTERS-1:0] hi_we;
    logic [NUM_COUNTERS-1:0] wrap;
    cfg_t                    cfg   [NUM_COUNTERS];
    logic [CNT_WIDTH-1:0]    count [NUM_COUNTERS];

    cfg_t                    sel_cfg;
    logic [63:0]             sel_cnt;
    logic [31:0]             rd_val;

    assign wr_en    = reg_req & reg_we;
    assign rd_en    = reg_req & ~reg_we;
    assign cnt_idx  = reg_addr[7:4] - 4'd4;
    assign cnt_off  = reg_addr[3:2];
    assign is_ctrl  = (reg_addr == ADDR_GLOBAL_CTRL);
    assign is_ovf   = (reg_addr == ADDR_OVF_STATUS);
    assign is_mask  = (reg_addr == ADDR_IRQ_MASK);
    assign is_info  = (reg_addr == ADDR_INFO);
    assign is_cnt   = (reg_addr[1:0] == 2'b00) && (reg_addr[7:6] != 2'b00)
                      && ({1'b0, cnt_idx} < NC5) && (cnt_off != 2'b11);
    assign mapped   = is_ctrl | is_ovf | is_mask | is_info | is_cnt;
    assign clear_all = wr_en & is_ctrl & reg_wdata[1];
    assign count_en  = enable_q & ~freeze;

    genvar g;
    generate
        for (g = 0; g < NUM_COUNTERS; g++) begin : g_slice
            assign cfg_we[g] = wr_en & is_cnt & (cnt_idx == 4'(g)) & (cnt_off == OFF_CFG);
            assign lo_we[g]  = wr_en & is_cnt & (cnt_idx == 4'(g)) & (cnt_off == OFF_LO);
            assign hi_we[g]  = wr_en & is_cnt & (cnt_idx == 4'(g)) & (cnt_off == OFF_HI);

            perf_counter_slice #(
                .NUM_EVENTS (NUM_EVENTS),
                .CNT_WIDTH  (CNT_WIDTH)
            ) u_slice (
                .clk_i      (clk),
                .rst_i      (rst),
                .events_i   (events),
                .count_en_i (count_en),
                .clear_i    (clear_all),
                .cfg_we_i   (cfg_we[g]),
                .lo_we_i    (lo_we[g]),
                .hi_we_i    (hi_we[g]),
                .wdata_i    (reg_wdata),
                .cfg_o      (cfg[g]),
                .count_o    (count[g]),
                .wrap_o     (wrap[g])
            );
        end
    endgenerate

`ifdef PERF_SNAPSHOT_EN
    logic                 snap_sel_q;
    logic [CNT_WIDTH-1:0] snap_q [NUM_COUNTERS];

    // The snapshot captures the pre-edge counts, so every counter sees the same instant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_sel_q <= 1'b0;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                snap_q[i] <= '0;
            end
        end else if (wr_en && is_ctrl) begin
            snap_sel_q <= reg_wdata[3];
            if (reg_wdata[2]) begin
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    snap_q[i] <= count[i];
                end
            end
        end
    end

    assign snap_sel_rd = snap_sel_q;
`else
    assign snap_sel_rd = 1'b0;
`endif

    always_comb begin
        sel_cfg = '0;
        sel_cnt = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (cnt_idx == 4'(i)) begin
                sel_cfg = cfg[i];
`ifdef PERF_SNAPSHOT_EN
                sel_cnt = snap_sel_q ? 64'(snap_q[i]) : 64'(count[i]);
`else
                sel_cnt = 64'(count[i]);
`endif
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (is_ctrl) begin
            rd_val = {28'd0, snap_sel_rd, 2'b00, enable_q};
        end else if (is_ovf) begin
            rd_val = 32'(ovf_q);
        end else if (is_mask) begin
            rd_val = 32'(irq_mask_q);
        end else if (is_info) begin
            rd_val = {8'(CNT_WIDTH), 8'(NUM_COUNTERS), 8'(NUM_EVENTS), INFO_VERSION};
        end else if (is_cnt) begin
            case (cnt_off)
                OFF_CFG: rd_val = 32'(sel_cfg);
                OFF_LO:  rd_val = sel_cnt[31:0];
                default: rd_val = shadow_q;
            endcase
        end
    end

    // A wrap in the same cycle as its W1C leaves the flag set.
    assign w1c   = (wr_en && is_ovf) ? reg_wdata[NUM_COUNTERS-1:0] : '0;
    assign ovf_d = (ovf_q & ~w1c) | wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q   <= 1'b0;
            irq_mask_q <= '0;
            ovf_q      <= '0;
            shadow_q   <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ack_q   <= reg_req;
            err_q   <= reg_req & ~mapped;
            rdata_q <= rd_en ? rd_val : '0;
            ovf_q   <= ovf_d;
            irq_q   <= |(ovf_q & irq_mask_q);
            if (wr_en && is_ctrl) begin
                enable_q <= reg_wdata[0];
            end
            if (wr_en && is_mask) begin
                irq_mask_q <= reg_wdata[NUM_COUNTERS-1:0];
            end
            if (rd_en && is_cnt && (cnt_off == OFF_LO)) begin
                shadow_q <= sel_cnt[63:32];
            end
        end
    end

    assign reg_rdata = rdata_q;
    assign reg_ack   = ack_q;
    assign reg_err   = err_q;
    assign ovf       = ovf_q;
    assign irq       = irq_q;

endmodule
